// File: rtl/trace_cmd_sequencer.sv
// trace_cmd_sequencer: buffers 40-bit trace commands in a FIFO and issues them
// one at a time to the L1 caches / MESI FSM, keeping per-opcode statistics.
module trace_cmd_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [39:0]      wr_cmd,
  output logic             wr_ready,
  output logic [39:0]      instruction,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             done,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned CMD_W      = 40;
  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W      = $clog2(DEPTH + 1);
  // The clear hand-off cycle is itself one blocked cycle, so the FLUSH state
  // only has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam int unsigned FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam int unsigned FCNT_W     = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [3:0] OP_READ  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_FETCH = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd8;
  localparam logic [3:0] OP_END   = 4'd15;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic [CMD_W-1:0]    mem_q [DEPTH];
  logic [CMD_W-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  logic [CMD_W-1:0]    instruction_q, instruction_d;
  logic                instr_valid_q, instr_valid_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    fe_cnt_q, fe_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                fifo_full, fifo_empty;
  logic                push, pop, out_hs, flush_hs;
  logic                pop_issue, pop_end, pop_err;
  logic [CMD_W-1:0]    head_cmd;
  logic [3:0]          head_op;

  function automatic logic op_issuable(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign fifo_full  = (occ_q == OCC_W'(DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign wr_ready   = !fifo_full && (state_q != ST_DONE);
  assign push       = wr_valid && wr_ready;
  assign head_cmd   = mem_q[rd_ptr_q];
  assign head_op    = head_cmd[39:36];
  assign out_hs     = instr_valid_q && instr_ready;
  // A clear command leaving the output register blocks the pop in the same cycle.
  assign flush_hs   = out_hs && (instruction_q[39:36] == OP_CLEAR);
  assign pop        = (state_q == ST_ISSUE) && !fifo_empty
                      && (!instr_valid_q || instr_ready) && !flush_hs;
  assign pop_issue  = pop && op_issuable(head_op);
  assign pop_end    = pop && (head_op == OP_END);
  assign pop_err    = pop && !op_issuable(head_op) && (head_op != OP_END);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ISSUE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state logic: end marker, clear-triggered flush window
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_ISSUE: begin
        if (pop_end) begin
          state_d = ST_DONE;
        end else if (flush_hs && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_LOAD);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_ISSUE;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_ISSUE;
    endcase
  end

  // Output/datapath next values: FIFO, output register, statistics
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    fe_cnt_d      = fe_cnt_q;
    err_cnt_d     = err_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (out_hs) begin
      instr_valid_d = 1'b0;
      case (instruction_q[39:36])
        OP_READ:  rd_cnt_d = sat_inc(rd_cnt_q);
        OP_WRITE: wr_cnt_d = sat_inc(wr_cnt_q);
        OP_FETCH: fe_cnt_d = sat_inc(fe_cnt_q);
        OP_CLEAR: begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          fe_cnt_d = '0;
        end
        default: ;
      endcase
    end
    if (pop_issue) begin
      instruction_d = head_cmd;
      instr_valid_d = 1'b1;
    end
    if (pop_err) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
    if (pop_end) begin
      done_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      fe_cnt_q      <= '0;
      err_cnt_q     <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      fe_cnt_q      <= fe_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign done        = done_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
  assign fetch_count = fe_cnt_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// tb_trace_cmd_sequencer: scoreboard bench for trace_cmd_sequencer.
module tb_trace_cmd_sequencer;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned FLUSH_CYCLES = 4;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             wr_valid;
  logic [39:0]      wr_cmd;
  logic             wr_ready;
  logic [39:0]      instruction;
  logic             instr_valid;
  logic             instr_ready;
  logic             done;
  logic [CNT_W-1:0] read_count, write_count, fetch_count, err_count;

  trace_cmd_sequencer #(
    .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_cmd(wr_cmd), .wr_ready(wr_ready),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .done(done),
    .read_count(read_count), .write_count(write_count),
    .fetch_count(fetch_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: which accepted commands must come out, and counter values
  logic [39:0] exp_q[$];
  int unsigned m_rd, m_wr, m_fe, m_err;
  bit          m_end;

  function automatic int unsigned sat(input int unsigned v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_rd = 0; m_wr = 0; m_fe = 0; m_err = 0; m_end = 1'b0;
  endfunction

  function automatic void model_push(input logic [39:0] w);
    int op;
    op = int'(w[39:36]);
    if (m_end) return;
    if (op == 15)                               m_end = 1'b1;
    else if (op <= 4 || op == 8 || op == 9)     exp_q.push_back(w);
    else                                        m_err = sat(m_err + 1);
  endfunction

  function automatic void model_issue(input logic [39:0] w);
    case (int'(w[39:36]))
      0:       m_rd = sat(m_rd + 1);
      1:       m_wr = sat(m_wr + 1);
      2:       m_fe = sat(m_fe + 1);
      8:       begin m_rd = 0; m_wr = 0; m_fe = 0; end
      default: ;
    endcase
  endfunction

  // Monitor: counters, hold stability, scoreboard pops on handshake
  bit          iv_prev, hs_prev, hold_pend, op8_pend;
  logic [39:0] hold_val, exp_w;
  int          op8_cyc, last_rise_cyc, last_flush_gap;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        iv_prev = 1'b0; hs_prev = 1'b0; hold_pend = 1'b0; op8_pend = 1'b0;
      end else begin
        check("read_count",  64'(read_count),  64'(m_rd));
        check("write_count", 64'(write_count), 64'(m_wr));
        check("fetch_count", 64'(fetch_count), 64'(m_fe));
        if (hold_pend) begin
          check("hold_valid", 64'(instr_valid), 64'(1));
          check("hold_instr", 64'(instruction), 64'(hold_val));
        end
        if (instr_valid && (!iv_prev || hs_prev)) begin
          last_rise_cyc = cyc;
          if (op8_pend) begin
            last_flush_gap = cyc - op8_cyc;
            check("flush_gap_min", 64'(last_flush_gap >= int'(FLUSH_CYCLES) + 1), 64'(1));
            op8_pend = 1'b0;
          end
        end
        if (instr_valid && instr_ready) begin
          check("issue_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("issued_cmd", 64'(instruction), 64'(exp_w));
            model_issue(exp_w);
            if (exp_w[39:36] == 4'd8) begin
              op8_pend = 1'b1;
              op8_cyc  = cyc;
            end
          end
          hold_pend = 1'b0;
        end else begin
          hold_pend = instr_valid;
          hold_val  = instruction;
        end
        iv_prev = instr_valid;
        hs_prev = instr_valid && instr_ready;
      end
    end
  end

  // instr_ready driver: 0 = stall, 1 = always ready, other = random
  int ir_mode = 1;
  initial begin
    instr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ir_mode)
        0:       instr_ready = 1'b0;
        1:       instr_ready = 1'b1;
        default: instr_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Stimulus: one push attempt per call, model updated only when accepted
  int push_cyc;
  bit acc;
  task automatic send(input logic [39:0] cmd, output bit accepted);
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    @(negedge clk);
    accepted = wr_ready && !rst;
    if (accepted) begin
      model_push(cmd);
      push_cyc = cyc;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic [39:0] cmd);
    bit a;
    for (int t = 0; t < 200; t++) begin
      send(cmd, a);
      if (a) return;
    end
    check("push_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_instr_valid", 64'(instr_valid), 64'(0));
    check("rst_instruction", 64'(instruction), 64'(0));
    check("rst_done",        64'(done),        64'(0));
    check("rst_wr_ready",    64'(wr_ready),    64'(1));
    check("rst_err_count",   64'(err_count),   64'(0));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    ir_mode = 1;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
    repeat (DEPTH + FLUSH_CYCLES + 8) @(posedge clk);
    @(negedge clk);
    check("err_count",      64'(err_count), 64'(m_err));
    check("done",           64'(done),      64'(m_end));
    check("wr_ready_drain", 64'(wr_ready),  64'(!m_end));
    @(posedge clk); #1;
  endtask

  function automatic logic [39:0] rand_cmd(input bit allow_end);
    int unsigned r, k;
    logic [3:0]  op;
    r = $urandom_range(0, 99);
    if (r < 60) begin
      k = $urandom_range(0, 5);
      op = (k == 5) ? 4'd9 : 4'(k);
    end else if (r < 70) begin
      op = 4'd8;
    end else if (r < 99 || !allow_end) begin
      k = $urandom_range(0, 7);
      op = (k < 3) ? 4'(5 + k) : 4'(10 + k - 3);
    end else begin
      op = 4'd15;
    end
    return {op, 32'($urandom), 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    int n_acc;
    rst = 1'b1; wr_valid = 1'b0; wr_cmd = '0;
    @(posedge clk); #1;
    do_reset();

    // Single read: push-to-valid latency, counter after handshake
    push_cmd({4'd0, 32'h984DE132, 4'h0});
    repeat (4) @(posedge clk);
    #1;
    check("latency_push_valid", 64'(last_rise_cyc - push_cyc), 64'(2));
    drain();
    check("single_read_count", 64'(read_count), 64'(1));

    // Back-pressure: output register plus DEPTH FIFO entries
    ir_mode = 0;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      send({4'(i % 5), 32'($urandom), 4'h0}, acc);
      if (acc) n_acc++;
    end
    @(negedge clk);
    check("full_accepts",  64'(n_acc),    64'(DEPTH + 1));
    check("full_wr_ready", 64'(wr_ready), 64'(0));
    @(posedge clk); #1;
    drain();

    // Clear command and flush window
    do_reset();
    push_cmd({4'd1, 32'h1000_0000, 4'h0});
    push_cmd({4'd2, 32'h2000_0000, 4'h0});
    push_cmd({4'd8, 32'h3000_0000, 4'h0});
    push_cmd({4'd0, 32'h4000_0000, 4'h0});
    drain();
    check("flush_gap",       64'(last_flush_gap), 64'(FLUSH_CYCLES + 1));
    check("flush_read_cnt",  64'(read_count),     64'(1));
    check("flush_write_cnt", 64'(write_count),    64'(0));
    check("flush_fetch_cnt", 64'(fetch_count),    64'(0));

    // Invalid opcode discarded, opcode 9 issued
    do_reset();
    push_cmd({4'd6, 32'hDEAD_BEEF, 4'h0});
    push_cmd({4'd9, 32'hCAFE_0000, 4'h0});
    drain();
    check("inv_err_count",  64'(err_count),   64'(1));
    check("inv_read_count", 64'(read_count),  64'(0));

    // End-of-trace marker
    do_reset();
    send({4'd0,  32'h0000_0100, 4'h0}, acc);
    send({4'd15, 32'h0,         4'h0}, acc);
    send({4'd1,  32'h0000_0200, 4'h0}, acc);
    drain();
    check("end_done",     64'(done),       64'(1));
    check("end_wr_ready", 64'(wr_ready),   64'(0));
    check("end_read_cnt", 64'(read_count), 64'(1));
    do_reset();

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 5; i++) push_cmd({4'd0, 32'($urandom), 4'h0});
    drain();
    check("sat_read_count", 64'(read_count), 64'(CNT_MAX));

    // Randomized rounds; every third round is aborted by reset mid-stream
    for (int r = 0; r < 8; r++) begin
      ir_mode = 2;
      do_reset();
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 3) != 0) send(rand_cmd(r >= 4), acc);
        else begin @(posedge clk); #1; end
      end
      if (r % 3 != 2) drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/trace_cmd_sequencer.md
TRACE_CMD_SEQUENCER -- requirements
Module: trace_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO depth in entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter FLUSH_CYCLES, default 4, issue-blocked cycles after a clear command (opcode 8).
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  trace source presents a command word.
REQ-007 wr_cmd  input  40  command word: [39:36] opcode n, [35:4] 32-bit address, [3:0] reserved (ignored).
REQ-008 wr_ready  output  1  FIFO can accept a command this cycle.
REQ-009 instruction  output  40  command word issued to the L1 data and instruction caches and the MESI FSM.
REQ-010 instr_valid  output  1  instruction holds a valid command.
REQ-011 instr_ready  input  1  downstream accepts instruction this cycle.
REQ-012 done  output  1  end-of-trace marker consumed; sticky.
REQ-013 read_count, write_count, fetch_count, err_count  output  CNT_W each  statistics counters.

Function
REQ-014 Push SHALL occur when wr_valid && wr_ready; wr_ready SHALL equal !full && !done, with no dependence on a same-cycle pop.
REQ-015 Pop SHALL occur only when the output register is empty or is being handed off (instr_valid && instr_ready), the state is ISSUE, and the FIFO is non-empty; the popped word SHALL appear on instruction with instr_valid=1 on the next cycle.
REQ-016 A command pushed into an empty FIFO SHALL NOT fall through; minimum latency from push to instr_valid is 2 cycles.
REQ-017 Once instr_valid=1, instruction SHALL hold stable until instr_ready=1.
REQ-018 Simultaneous push and pop SHALL keep the occupancy unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 States: ISSUE, FLUSH, DONE. The state after reset is ISSUE.
REQ-020 Opcodes SHALL be classified at pop time as follows:
- 0, 1, 2, 3, 4, 8, 9: valid; loaded into the output register.
- 5-7 and 10-14: invalid; discarded, not issued; err_count increments.
- 15: end-of-trace marker; not issued; state goes to DONE.
REQ-021 On handshake of opcode 0, read_count SHALL increment; opcode 1 increments write_count; opcode 2 increments fetch_count; opcodes 3, 4 and 9 leave all counters unchanged.
REQ-022 On handshake of opcode 8, read_count, write_count and fetch_count SHALL clear to 0 (err_count is retained) and the state SHALL go to FLUSH.
REQ-023 FLUSH SHALL block pops for exactly FLUSH_CYCLES cycles, then return to ISSUE. Pushes remain allowed during FLUSH.
REQ-024 DONE SHALL assert done=1 and keep wr_ready=0. DONE is left only by rst, and any remaining FIFO entries are not issued.
REQ-025 A command already in the output register when opcode 15 is popped SHALL still complete its handshake. Opcode 15 is popped only when the output register is empty or handing off.
REQ-026 All counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-027 While rst=1, the following SHALL hold on the next clock edge, with rst overriding any same-cycle push, pop or handshake:
- FIFO emptied; pointers = 0.
- state = ISSUE; instruction = 40'h0; instr_valid = 0; done = 0.
- All counters = 0.
REQ-028 rst asserted mid-FLUSH or mid-handshake SHALL abort the operation, with no counter increment for the aborted command.

Verification
REQ-029 Push {0, 32'h984DE132, 4'h0} into an empty FIFO with instr_ready=1 -> instr_valid rises 2 cycles after the push; read_count=1 after the handshake.
REQ-030 Push DEPTH+1 commands back-to-back with instr_ready=0 -> the output register holds 1 command and the FIFO holds DEPTH, so wr_ready=0 after DEPTH+1 accepts; the last command is stalled; instruction stays stable throughout.
REQ-031 Sequence opcode 1, 2, 8, 0 with instr_ready=1 -> write_count and fetch_count reach 1, then clear at the opcode-8 handshake; opcode 0 issues exactly FLUSH_CYCLES+1 cycles after the opcode-8 handshake; final read_count=1.
REQ-032 Push opcode 6, then opcode 9 -> opcode 6 is never issued and err_count=1; opcode 9 is issued and all other counters are unchanged.
REQ-033 Push opcode 0, 15, 1 -> opcode 0 is issued, done=1, opcode 1 is never issued, wr_ready=0; then rst -> all outputs return to their reset values.
REQ-034 Force read_count to 2^CNT_W-1 and issue opcode 0 -> read_count stays at 2^CNT_W-1.
